fxp_multiplier: RTL and testbench

Sequential unsigned fixed-point multiplier that is the inverse of the team's shift-subtract divider datapath. It shares the divider's operand format and start/busy/valid handshake, so the two blocks can sit on the same operand bus and be exercised by the same bench style. It is a radix-2 shift-add unit: one multiplier bit per clock, producing a truncated, saturating fixed-point product with an overflow flag.

---
 rtl/fxp_multiplier.sv | 117 +++++++++++
 tb/tb_fxp_multiplier.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_multiplier.sv
// Radix-2 shift-add unsigned fixed-point multiplier: one multiplier bit per clock,
// truncated Q(WIDTH-FRAC).FRAC product that saturates to all ones on integer overflow.
module fxp_multiplier #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start,
  input  logic             sclr,
  output logic [WIDTH-1:0] q_out,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [2*WIDTH-1:0]   p_sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    p_sum   = p_q + (b_q[0] ? a_q : '0);

    if (sclr) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      p_d     = '0;
      cnt_d   = '0;
      q_d     = '0;
      ovf_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = {{WIDTH{1'b0}}, a_in};
            b_d     = b_in;
            p_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
        CALC: begin
          p_d   = p_sum;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          // Result is formed from the final partial sum in the same edge it is accumulated.
          if (cnt_q == LAST) begin
            ovf_d   = |p_sum[2*WIDTH-1:WIDTH+FRAC];
            q_d     = ovf_d ? '1 : p_sum[WIDTH+FRAC-1:FRAC];
            valid_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign q_out = q_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_fxp_multiplier.sv
// Self-checking bench for fxp_multiplier: fixed vectors, randomized operands against an
// arithmetic product model, held-start throughput, and asynchronous/synchronous clears.
module tb_fxp_multiplier;

  localparam int WIDTH = 10;
  localparam int FRAC  = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             start;
  logic             sclr;
  logic [WIDTH-1:0] q_out;
  logic             ovf;
  logic             busy;
  logic             valid;

  int checks = 0;
  int errors = 0;

  fxp_multiplier #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst   (rst),
    .a_in  (a_in),
    .b_in  (b_in),
    .start (start),
    .sclr  (sclr),
    .q_out (q_out),
    .ovf   (ovf),
    .busy  (busy),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic             o;
    string            name;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact integer product, saturate when it needs more than WIDTH+FRAC bits.
  function automatic void model(input int a, input int b, output int q, output int o);
    longint prod;
    prod = longint'(a) * longint'(b);
    o = (prod >= (longint'(1) << (WIDTH + FRAC))) ? 1 : 0;
    q = (o != 0) ? ((1 << WIDTH) - 1) : int'((prod >> FRAC) % (longint'(1) << WIDTH));
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int exp_q, input int exp_o, input string nm);
    int n;
    int busy_gaps;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy_after_accept"}, int'(busy), 1);
    a_in = WIDTH'($urandom);
    b_in = WIDTH'($urandom);
    n = 0;
    busy_gaps = 0;
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!valid && !busy) busy_gaps++;
      if (valid && busy) busy_gaps++;
    end
    chk({nm, " latency"}, n, WIDTH);
    chk({nm, " busy_profile"}, busy_gaps, 0);
    chk({nm, " q_out"}, int'(q_out), exp_q);
    chk({nm, " ovf"}, int'(ovf), exp_o);
    @(posedge clk); #1;
    chk({nm, " valid_one_cycle"}, int'(valid), 0);
    chk({nm, " q_hold"}, int'(q_out), exp_q);
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid) cnt++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int eq, eo, nv;
    logic [WIDTH-1:0] ha[4];
    logic [WIDTH-1:0] hb[4];

    vecs[0] = '{a: 10'b0001000000, b: 10'b0001100000, q: 10'b0011000000, o: 1'b0, name: "basic_2x3"};
    vecs[1] = '{a: 10'b0000110000, b: 10'b0000100001, q: 10'b0000110001, o: 1'b0, name: "frac_trunc"};
    vecs[2] = '{a: 10'b1111111111, b: 10'b0001000000, q: 10'b1111111111, o: 1'b1, name: "ovf_sat"};
    vecs[3] = '{a: 10'd0,          b: 10'b1111111111, q: 10'd0,          o: 1'b0, name: "zero_a"};
    vecs[4] = '{a: 10'd1023,       b: 10'd32,         q: 10'd1023,       o: 1'b0, name: "max_no_ovf"};
    vecs[5] = '{a: 10'd512,        b: 10'd64,         q: 10'd1023,       o: 1'b1, name: "min_ovf"};
    vecs[6] = '{a: 10'd1,          b: 10'd1,          q: 10'd0,          o: 1'b0, name: "tiny_trunc"};
    vecs[7] = '{a: 10'd1023,       b: 10'd1023,       q: 10'd1023,       o: 1'b1, name: "max_max"};

    rst   = 1'b0;
    sclr  = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset q_out", int'(q_out), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset valid", int'(valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, int'(vecs[i].q), int'(vecs[i].o), vecs[i].name);

    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom >> (i % 6));
      model(int'(ra), int'(rb), eq, eo);
      run_op(ra, rb, eq, eo, "random");
    end

    // Held start: results every WIDTH+1 cycles, operands changed mid-CALC.
    ha[0] = 10'b1000001000; hb[0] = 10'b0001110100;
    ha[1] = 10'd48;         hb[1] = 10'd33;
    ha[2] = 10'd0;          hb[2] = 10'd1023;
    ha[3] = 10'd64;         hb[3] = 10'd96;
    @(negedge clk);
    a_in  = ha[0];
    b_in  = hb[0];
    start = 1'b1;
    @(posedge clk); #1;
    chk("held accept busy", int'(busy), 1);
    for (int op = 0; op < 3; op++) begin
      for (int cyc = 1; cyc <= WIDTH; cyc++) begin
        @(posedge clk); #1;
        if (cyc == 5) begin
          a_in = ha[op+1];
          b_in = hb[op+1];
        end
        if (cyc < WIDTH) chk("held busy_guard", int'(busy && !valid), 1);
      end
      model(int'(ha[op]), int'(hb[op]), eq, eo);
      chk("held valid", int'(valid), 1);
      chk("held busy_low", int'(busy), 0);
      chk("held q_out", int'(q_out), eq);
      chk("held ovf", int'(ovf), eo);
      @(posedge clk); #1;
      chk("held reaccept", int'({valid, busy}), 1);
    end
    start = 1'b0;
    count_valids(WIDTH + 2, nv);
    chk("held drain valids", nv, 1);
    chk("held drain q_out", int'(q_out), 192);

    // Asynchronous reset in the middle of CALC.
    run_op(10'd64, 10'd96, 192, 0, "pre_rst");
    @(negedge clk);
    a_in = 10'd1023; b_in = 10'd1023; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst busy", int'(busy), 0);
    chk("async rst q_out", int'(q_out), 0);
    chk("async rst ovf", int'(ovf), 0);
    #2 rst = 1'b0;
    count_valids(15, nv);
    chk("async rst no_valid", nv, 0);
    run_op(10'd48, 10'd33, 49, 0, "post_rst");

    // Synchronous clear in the middle of CALC.
    run_op(10'd1023, 10'd64, 1023, 1, "pre_sclr");
    @(negedge clk);
    a_in = 10'd64; b_in = 10'd96; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 sclr = 1'b1;
    start = 1'b1;
    chk("sclr before edge busy", int'(busy), 1);
    @(posedge clk); #1;
    sclr  = 1'b0;
    start = 1'b0;
    chk("sclr busy", int'(busy), 0);
    chk("sclr q_out", int'(q_out), 0);
    chk("sclr ovf", int'(ovf), 0);
    count_valids(15, nv);
    chk("sclr no_valid", nv, 0);
    run_op(10'b1000001000, 10'b0001110100, 1023, 1, "post_sclr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
